// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: filters raw pad lines, deframes 11-bit frames, strips F0/E0 prefixes.
// Optional left/right shift tracking is compiled in with `define PS2_SHIFT_TRACK_EN.
module ps2_kb_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       scan_ack,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       is_break,
   output logic       is_extended,
   output logic       frame_err,
   output logic       overflow,
   output logic       shift_pressed
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   function automatic logic odd_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   logic r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
   logic r_filt, r_fall;
   logic [FW-1:0] r_filt_cnt;
   state_t r_state, w_state_nx;
   logic [2:0] r_bit_cnt, w_bit_cnt_nx;
   logic [7:0] r_sreg, w_sreg_nx;
   logic r_par, w_par_nx;
   logic [TW-1:0] r_to_cnt;
   logic r_brk_pend, r_ext_pend;
   logic [7:0] r_code;
   logic r_valid, r_is_brk, r_is_ext, r_ferr, r_ovf;
   logic w_byte_ok, w_err, w_timeout, w_code_evt;

   // Synchronizers, clock glitch filter and falling-edge strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
         r_filt     <= 1'b1;
         r_filt_cnt <= '0;
         r_fall     <= 1'b0;
      end else begin
         r_clk_meta <= ps2_clk;
         r_clk_sync <= r_clk_meta;
         r_dat_meta <= ps2_data;
         r_dat_sync <= r_dat_meta;
         r_fall     <= 1'b0;
         if (r_clk_sync != r_filt) begin
            if (r_filt_cnt == FLT_LAST) begin
               r_filt     <= r_clk_sync;
               r_fall     <= r_filt;
               r_filt_cnt <= '0;
            end else begin
               r_filt_cnt <= r_filt_cnt + {{(FW-1){1'b0}}, 1'b1};
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_LIM);

   // Frame FSM next state; a fall in the same cycle as expiry wins over the timeout
   always_comb begin
      w_state_nx   = r_state;
      w_bit_cnt_nx = r_bit_cnt;
      w_sreg_nx    = r_sreg;
      w_par_nx     = r_par;
      w_byte_ok    = 1'b0;
      w_err        = 1'b0;
      if (w_timeout && !r_fall) begin
         w_state_nx   = S_IDLE;
         w_bit_cnt_nx = 3'd0;
         w_err        = 1'b1;
      end else if (r_fall) begin
         case (r_state)
            S_IDLE: begin
               if (!r_dat_sync) begin
                  w_state_nx   = S_DATA;
                  w_bit_cnt_nx = 3'd0;
               end else begin
                  w_state_nx = S_IDLE;
               end
            end
            S_DATA: begin
               w_sreg_nx    = {r_dat_sync, r_sreg[7:1]};
               w_bit_cnt_nx = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nx = S_PARITY;
               end else begin
                  w_state_nx = S_DATA;
               end
            end
            S_PARITY: begin
               w_par_nx   = r_dat_sync;
               w_state_nx = S_STOP;
            end
            S_STOP: begin
               w_state_nx = S_IDLE;
               if (r_dat_sync && odd_ok(r_sreg, r_par)) begin
                  w_byte_ok = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end else begin
         w_state_nx = r_state;
      end
   end

   assign w_code_evt = w_byte_ok && (r_sreg != 8'hF0) && (r_sreg != 8'hE0);

   // FSM, timeout counter, prefix flags and the one-entry holding register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= 3'd0;
         r_sreg     <= 8'h00;
         r_par      <= 1'b0;
         r_to_cnt   <= '0;
         r_brk_pend <= 1'b0;
         r_ext_pend <= 1'b0;
         r_code     <= 8'h00;
         r_valid    <= 1'b0;
         r_is_brk   <= 1'b0;
         r_is_ext   <= 1'b0;
         r_ferr     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_bit_cnt <= w_bit_cnt_nx;
         r_sreg    <= w_sreg_nx;
         r_par     <= w_par_nx;
         r_ferr    <= w_err;
         r_ovf     <= 1'b0;
         if (r_fall || r_state == S_IDLE) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + {{(TW-1){1'b0}}, 1'b1};
         end
         if (w_err) begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
         end else if (w_byte_ok) begin
            if (r_sreg == 8'hF0) begin
               r_brk_pend <= 1'b1;
            end else if (r_sreg == 8'hE0) begin
               r_ext_pend <= 1'b1;
            end else begin
               r_brk_pend <= 1'b0;
               r_ext_pend <= 1'b0;
            end
         end else begin
            r_brk_pend <= r_brk_pend;
         end
         if (w_code_evt) begin
            if (!r_valid || scan_ack) begin
               r_code   <= r_sreg;
               r_is_brk <= r_brk_pend;
               r_is_ext <= r_ext_pend;
               r_valid  <= 1'b1;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (r_valid && scan_ack) begin
            r_valid <= 1'b0;
         end else begin
            r_valid <= r_valid;
         end
      end
   end

   assign scan_code   = r_code;
   assign scan_valid  = r_valid;
   assign is_break    = r_is_brk;
   assign is_extended = r_is_ext;
   assign frame_err   = r_ferr;
   assign overflow    = r_ovf;

`ifdef PS2_SHIFT_TRACK_EN
   logic r_lshift, r_rshift, r_shift_pr;
   logic w_lshift_nx, w_rshift_nx;

   // Shift key state follows every non-extended code event, dropped or not
   always_comb begin
      w_lshift_nx = r_lshift;
      w_rshift_nx = r_rshift;
      if (w_code_evt && !r_ext_pend) begin
         if (r_sreg == 8'h12) begin
            w_lshift_nx = !r_brk_pend;
         end else if (r_sreg == 8'h59) begin
            w_rshift_nx = !r_brk_pend;
         end else begin
            w_lshift_nx = r_lshift;
         end
      end else begin
         w_rshift_nx = r_rshift;
      end
   end

   // Shift state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lshift   <= 1'b0;
         r_rshift   <= 1'b0;
         r_shift_pr <= 1'b0;
      end else begin
         r_lshift   <= w_lshift_nx;
         r_rshift   <= w_rshift_nx;
         r_shift_pr <= w_lshift_nx | w_rshift_nx;
      end
   end

   assign shift_pressed = r_shift_pr;
`else
   assign shift_pressed = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: bit-banged PS/2 frames, pulse counters, hand-computed expectations.
module tb_ps2_kb_rx;
   localparam int HALF = 40;
   localparam int TO   = 300;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   logic scan_ack = 1'b0;
   logic [7:0] scan_code;
   logic scan_valid, is_break, is_extended, frame_err, overflow, shift_pressed;

   int n_vec = 0;
   int n_mis = 0;
   int err_cnt = 0;
   int ovf_cnt = 0;
   int evt_cnt = 0;
   int exp_err = 0;
   int exp_evt = 0;
   logic prev_valid = 1'b0;

   ps2_kb_rx #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .scan_ack(scan_ack), .scan_code(scan_code), .scan_valid(scan_valid),
      .is_break(is_break), .is_extended(is_extended), .frame_err(frame_err),
      .overflow(overflow), .shift_pressed(shift_pressed)
   );

   always #5 clk = ~clk;

   // Pulse and event counters sampled on the inactive edge
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) err_cnt++;
         if (overflow) ovf_cnt++;
         if (scan_valid && !prev_valid) evt_cnt++;
         prev_valid = scan_valid;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF/2) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
         repeat (HALF/2) @(posedge clk);
      end
      ps2_data = 1'b1;
      repeat (HALF) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
      logic par;
      par = (~^b) ^ par_flip;
      send_bits({stop, par, b, 1'b0}, 11);
   endtask

   task automatic do_ack();
      @(negedge clk);
      scan_ack = 1'b1;
      @(negedge clk);
      scan_ack = 1'b0;
      chk("ack_clears_valid", {31'd0, scan_valid}, 32'd0);
   endtask

   task automatic chk_evt(input string tag, input logic [7:0] code, input logic brk, input logic ext);
      @(negedge clk);
      chk({tag, "_valid"}, {31'd0, scan_valid}, 32'd1);
      chk({tag, "_code"}, {24'd0, scan_code}, {24'd0, code});
      chk({tag, "_brk"}, {31'd0, is_break}, {31'd0, brk});
      chk({tag, "_ext"}, {31'd0, is_extended}, {31'd0, ext});
      chk({tag, "_nevt"}, evt_cnt, exp_evt);
   endtask

   initial begin
      repeat (5) @(posedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", {31'd0, scan_valid}, 32'd0);
      chk("rst_code", {24'd0, scan_code}, 32'd0);
      chk("rst_flags", {29'd0, is_break, is_extended, shift_pressed}, 32'd0);
      chk("rst_pulses", {30'd0, frame_err, overflow}, 32'd0);

      // 1: plain make code, held until acked
      send_frame(8'h1C, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t1", 8'h1C, 1'b0, 1'b0);
      repeat (200) @(posedge clk);
      chk_evt("t1_hold", 8'h1C, 1'b0, 1'b0);
      do_ack();

      // 2: break prefix
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t2_brk", 8'h1C, 1'b1, 1'b0);
      do_ack();
      send_frame(8'h1C, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t2_make", 8'h1C, 1'b0, 1'b0);
      do_ack();

      // 3: extended break
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t3", 8'h75, 1'b1, 1'b1);
      do_ack();

      // 4: parity error, then stop error clearing the pending break
      send_frame(8'h1C, 1'b1, 1'b1);
      exp_err++;
      chk("t4_par_err", err_cnt, exp_err);
      chk("t4_no_valid", {31'd0, scan_valid}, 32'd0);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h33, 1'b0, 1'b0);
      exp_err++;
      chk("t4_stop_err", err_cnt, exp_err);
      send_frame(8'h1C, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t4_after", 8'h1C, 1'b0, 1'b0);
      do_ack();

      // Idle-line fall with data high, then a short clock glitch: neither is an error
      send_bits(11'h7FF, 1);
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      repeat (4) @(posedge clk);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (HALF) @(posedge clk);
      send_frame(8'h4D, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("glitch", 8'h4D, 1'b0, 1'b0);
      chk("glitch_no_err", err_cnt, exp_err);
      do_ack();

      // 5: timeout after start + 5 data bits
      send_bits({5'b00000, 6'b101010}, 6);
      repeat (TO + 10) @(posedge clk);
      exp_err++;
      chk("t5_timeout_err", err_cnt, exp_err);
      chk("t5_no_valid", {31'd0, scan_valid}, 32'd0);
      send_frame(8'h2A, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t5_recover", 8'h2A, 1'b0, 1'b0);
      chk("t5_err_total", err_cnt, exp_err);
      do_ack();

      // 6: overflow on unacked second code
      send_frame(8'h1C, 1'b0, 1'b1);
      exp_evt++;
      send_frame(8'h32, 1'b0, 1'b1);
      chk_evt("t6", 8'h1C, 1'b0, 1'b0);
      chk("t6_ovf", ovf_cnt, 32'd1);
      do_ack();
`ifdef PS2_SHIFT_TRACK_EN
      send_frame(8'h12, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t6_lshift", 8'h12, 1'b0, 1'b0);
      chk("t6_shift_on", {31'd0, shift_pressed}, 32'd1);
      do_ack();
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h12, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t6_lshift_brk", 8'h12, 1'b1, 1'b0);
      chk("t6_shift_off", {31'd0, shift_pressed}, 32'd0);
      do_ack();
`else
      send_frame(8'h12, 1'b0, 1'b1);
      exp_evt++;
      chk_evt("t6_lshift", 8'h12, 1'b0, 1'b0);
      chk("t6_shift_tied", {31'd0, shift_pressed}, 32'd0);
      do_ack();
`endif
      chk("final_err_total", err_cnt, exp_err);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
